control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_pkg.sv | 76 +++++++
 rtl/control_sequencer_if.sv | 38 +++
 rtl/control_decode.sv | 45 ++++
 rtl/control_sequencer.sv | 82 ++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared types and encodings for the control sequencer: FSM states,
// instruction fields, the strobe bundle and the reset constants.
package control_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_IMM   = 3'd3,
      ST_JUMP  = 3'd4,
      ST_HALT  = 3'd5
   } seqState_t;

   typedef enum logic [1:0] {
      OP_MOV = 2'd0,
      OP_JMP = 2'd1,
      OP_HLT = 2'd2,
      OP_NOP = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      SRC_A    = 2'd0,
      SRC_X    = 2'd1,
      SRC_IMM  = 2'd2,
      SRC_NONE = 2'd3
   } src_t;

   typedef enum logic [1:0] {
      DST_A = 2'd0,
      DST_B = 2'd1,
      DST_X = 2'd2,
      DST_Q = 2'd3
   } dst_t;

   // load is ordered {q, x, b, a}
   typedef struct packed {
      logic       romOeBar;
      logic       assertBarA;
      logic       assertBarX;
      logic [3:0] load;
      logic       halted;
   } strobes_t;

   localparam logic [7:0] RESET_PC = 8'h00;
   localparam logic [7:0] RESET_IR = 8'h00;

   localparam strobes_t STROBES_IDLE = '{romOeBar: 1'b1, assertBarA: 1'b1,
                                         assertBarX: 1'b1, load: 4'b0000,
                                         halted: 1'b0};

   // code is ir[7:2]; the two low instruction bits carry no meaning
   function automatic op_t opOf(input logic [5:0] code);
      return op_t'(code[5:4]);
   endfunction

   function automatic src_t srcOf(input logic [5:0] code);
      return src_t'(code[3:2]);
   endfunction

   function automatic dst_t dstOf(input logic [5:0] code);
      return dst_t'(code[1:0]);
   endfunction

   function automatic logic [3:0] dstLoad(input dst_t d);
      logic [3:0] vec;
      case (d)
         DST_A:   vec = 4'b0001;
         DST_B:   vec = 4'b0010;
         DST_X:   vec = 4'b0100;
         DST_Q:   vec = 4'b1000;
         default: vec = 4'b0000;
      endcase
      return vec;
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bus-side signals of the control sequencer; master is the sequencer.
// The step line exists only when SEQ_SINGLE_STEP_EN is defined.
interface control_sequencer_if;

   logic [7:0] dbus;
   logic [7:0] pc;
   logic [7:0] ir;
   logic       rom_oe_bar;
   logic       load_a;
   logic       load_b;
   logic       load_x;
   logic       load_q;
   logic       assert_bar_a;
   logic       assert_bar_x;
   logic       halted;
`ifdef SEQ_SINGLE_STEP_EN
   logic       step;
`endif

   modport master (
      input  dbus,
`ifdef SEQ_SINGLE_STEP_EN
      input  step,
`endif
      output pc, ir, rom_oe_bar, load_a, load_b, load_x, load_q,
             assert_bar_a, assert_bar_x, halted
   );

   modport slave (
      output dbus,
`ifdef SEQ_SINGLE_STEP_EN
      output step,
`endif
      input  pc, ir, rom_oe_bar, load_a, load_b, load_x, load_q,
             assert_bar_a, assert_bar_x, halted
   );

endinterface

// File: rtl/control_decode.sv
// Purely combinational strobe decode from the FSM state and the
// meaningful instruction bits ir[7:2].
module control_decode
   import control_sequencer_pkg::*;
(
   input  seqState_t  state,
   input  logic [5:0] irCode,
   output strobes_t   strobes
);

   // Map state and instruction fields to bus strobes; at most one bus driver.
   always_comb begin
      strobes = STROBES_IDLE;
      case (state)
         ST_IDLE: begin
            strobes = STROBES_IDLE;
         end
         ST_FETCH, ST_JUMP: begin
            strobes.romOeBar = 1'b0;
         end
         ST_EXEC: begin
            if (opOf(irCode) == OP_MOV && srcOf(irCode) == SRC_A) begin
               strobes.assertBarA = 1'b0;
               strobes.load       = dstLoad(dstOf(irCode));
            end else if (opOf(irCode) == OP_MOV && srcOf(irCode) == SRC_X) begin
               strobes.assertBarX = 1'b0;
               strobes.load       = dstLoad(dstOf(irCode));
            end else begin
               strobes = STROBES_IDLE;
            end
         end
         ST_IMM: begin
            strobes.romOeBar = 1'b0;
            strobes.load     = dstLoad(dstOf(irCode));
         end
         ST_HALT: begin
            strobes.halted = 1'b1;
         end
         default: begin
            strobes = STROBES_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control sequencer: holds state, pc and ir; strobes come from
// control_decode. Define SEQ_SINGLE_STEP_EN to gate every state on step.
module control_sequencer
   import control_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   control_sequencer_if.master bus
);

   seqState_t  state_r;
   logic [7:0] pc_r;
   logic [7:0] ir_r;
   logic       advance_s;
   strobes_t   strobes_s;

`ifdef SEQ_SINGLE_STEP_EN
   assign advance_s = bus.step;
`else
   assign advance_s = 1'b1;
`endif

   // Sequencer FSM with pc and ir; only dbus feeds data into the registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         pc_r    <= RESET_PC;
         ir_r    <= RESET_IR;
      end else if (advance_s) begin
         case (state_r)
            ST_IDLE: begin
               state_r <= ST_FETCH;
            end
            ST_FETCH: begin
               ir_r    <= bus.dbus;
               pc_r    <= pc_r + 8'd1;
               state_r <= ST_EXEC;
            end
            ST_EXEC: begin
               case (opOf(ir_r[7:2]))
                  OP_MOV:  state_r <= (srcOf(ir_r[7:2]) == SRC_IMM) ? ST_IMM : ST_FETCH;
                  OP_JMP:  state_r <= ST_JUMP;
                  OP_HLT:  state_r <= ST_HALT;
                  default: state_r <= ST_FETCH;
               endcase
            end
            ST_IMM: begin
               pc_r    <= pc_r + 8'd1;
               state_r <= ST_FETCH;
            end
            ST_JUMP: begin
               pc_r    <= bus.dbus;
               state_r <= ST_FETCH;
            end
            ST_HALT: begin
               state_r <= ST_HALT;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   control_decode u_decode (
      .state   (state_r),
      .irCode  (ir_r[7:2]),
      .strobes (strobes_s)
   );

   assign bus.pc           = pc_r;
   assign bus.ir           = ir_r;
   assign bus.rom_oe_bar   = strobes_s.romOeBar;
   assign bus.assert_bar_a = strobes_s.assertBarA;
   assign bus.assert_bar_x = strobes_s.assertBarX;
   assign bus.load_a       = strobes_s.load[0];
   assign bus.load_b       = strobes_s.load[1];
   assign bus.load_x       = strobes_s.load[2];
   assign bus.load_q       = strobes_s.load[3];
   assign bus.halted       = strobes_s.halted;

endmodule
